// File: rtl/vlc_lamp_decoder.sv
// Turn-signal lamp sequence decoder: classifies lamp transitions, locks onto a
// repeating class after LOCK_N consecutive legal steps, and counts illegal samples.
module vlc_lamp_decoder #(
  parameter int LOCK_N = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic [2:0] left_lamp,
  input  logic [2:0] right_lamp,
  output logic [1:0] mode,
  output logic       locked,
  output logic       fault,
  output logic [7:0] err_cnt
);

  typedef enum logic [2:0] {
    S_Z  = 3'd0, S_L1 = 3'd1, S_L2 = 3'd2, S_L3 = 3'd3,
    S_R1 = 3'd4, S_R2 = 3'd5, S_R3 = 3'd6, S_H  = 3'd7
  } samp_e;

  localparam logic [1:0] C_IDLE  = 2'b00;
  localparam logic [1:0] C_LEFT  = 2'b01;
  localparam logic [1:0] C_RIGHT = 2'b10;
  localparam logic [1:0] C_HAZ   = 2'b11;
  localparam logic [2:0] LOCK_Q  = 3'(LOCK_N);

  // {valid, step}: step 0..3 for 000/001/011/111, valid=0 for any other pattern
  function automatic logic [2:0] lamp_pos(input logic [2:0] p);
    case (p)
      3'b000:  lamp_pos = 3'b100;
      3'b001:  lamp_pos = 3'b101;
      3'b011:  lamp_pos = 3'b110;
      3'b111:  lamp_pos = 3'b111;
      default: lamp_pos = 3'b000;
    endcase
  endfunction

  function automatic logic [2:0] sat_inc3(input logic [2:0] v);
    sat_inc3 = (v == 3'd7) ? v : v + 3'd1;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    sat_inc8 = (v == 8'd255) ? v : v + 8'd1;
  endfunction

  samp_e      prev_q, prev_d, cur;
  logic [1:0] cand_q, cand_d, mode_q, mode_d, tcls;
  logic [2:0] run_q, run_d, pl, pr;
  logic       locked_q, locked_d, fault_q, fault_d, valid, legal;
  logic [7:0] err_q, err_d;

  always_comb begin
    pl    = lamp_pos(left_lamp);
    pr    = lamp_pos(right_lamp);
    valid = 1'b1;
    cur   = S_Z;
    if (!pl[2] || !pr[2])                       valid = 1'b0;
    else if (pl[1:0] == 2'd0 && pr[1:0] == 2'd0) cur   = S_Z;
    else if (pr[1:0] == 2'd0)                   cur   = samp_e'({1'b0, pl[1:0]});
    else if (pl[1:0] == 2'd0)                   cur   = samp_e'(3'd3 + {1'b0, pr[1:0]});
    else if (pl[1:0] == 2'd3 && pr[1:0] == 2'd3) cur   = S_H;
    else                                        valid = 1'b0;
  end

  always_comb begin
    legal = 1'b0;
    tcls  = C_IDLE;
    if (valid) begin
      case ({prev_q, cur})
        {S_Z, S_Z}: begin legal = 1'b1; tcls = C_IDLE; end
        {S_Z, S_L1}, {S_L1, S_L2}, {S_L2, S_L3}, {S_L3, S_Z}:
          begin legal = 1'b1; tcls = C_LEFT; end
        {S_Z, S_R1}, {S_R1, S_R2}, {S_R2, S_R3}, {S_R3, S_Z}:
          begin legal = 1'b1; tcls = C_RIGHT; end
        {S_Z, S_H}, {S_H, S_Z}:
          begin legal = 1'b1; tcls = C_HAZ; end
        default: ;
      endcase
    end
  end

  always_comb begin
    prev_d   = prev_q;
    cand_d   = cand_q;
    run_d    = run_q;
    mode_d   = mode_q;
    locked_d = locked_q;
    err_d    = err_q;
    fault_d  = 1'b0;
    if (tick) begin
      if (legal) begin
        prev_d = cur;
        if (tcls == cand_q) begin
          run_d = sat_inc3(run_q);
        end else begin
          cand_d = tcls;
          run_d  = 3'd1;
        end
        locked_d = (run_d >= LOCK_Q);
        if (locked_d) mode_d = cand_d;
      end else begin
        // Invalid samples restart the sequence from Z so the next lamp step can be legal
        prev_d   = valid ? cur : S_Z;
        fault_d  = 1'b1;
        err_d    = sat_inc8(err_q);
        run_d    = 3'd0;
        locked_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q   <= S_Z;
      cand_q   <= C_IDLE;
      run_q    <= 3'd0;
      mode_q   <= C_IDLE;
      locked_q <= 1'b0;
      fault_q  <= 1'b0;
      err_q    <= 8'd0;
    end else begin
      prev_q   <= prev_d;
      cand_q   <= cand_d;
      run_q    <= run_d;
      mode_q   <= mode_d;
      locked_q <= locked_d;
      fault_q  <= fault_d;
      err_q    <= err_d;
    end
  end

  assign mode    = mode_q;
  assign locked  = locked_q;
  assign fault   = fault_q;
  assign err_cnt = err_q;

endmodule

// File: tb/tb_vlc_lamp_decoder.sv
// Scoreboard bench for vlc_lamp_decoder: directed scenarios plus randomized lamp
// sequences checked against a family/step reference model.
module tb_vlc_lamp_decoder;
  localparam int LOCK_N = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b0;
  logic [2:0] left_lamp = 3'b000;
  logic [2:0] right_lamp = 3'b000;
  logic [1:0] mode;
  logic       locked, fault;
  logic [7:0] err_cnt;

  always #5 clk = ~clk;

  vlc_lamp_decoder #(.LOCK_N(LOCK_N)) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .left_lamp(left_lamp),
    .right_lamp(right_lamp), .mode(mode), .locked(locked), .fault(fault),
    .err_cnt(err_cnt)
  );

  typedef struct {
    int mode;
    int locked;
    int fault;
    int err;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   failures = 0;

  // Reference state: a sample is (family, step); family 0 = Z, 1 = left, 2 = right, 3 = hazard
  int m_pf, m_ps, m_cand, m_run, m_mode, m_locked, m_err;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pf = 0; m_ps = 0; m_cand = 0; m_run = 0; m_mode = 0; m_locked = 0; m_err = 0;
  endtask

  function automatic int pos(input logic [2:0] p);
    case (p)
      3'b000:  return 0;
      3'b001:  return 1;
      3'b011:  return 2;
      3'b111:  return 3;
      default: return -1;
    endcase
  endfunction

  function automatic logic [2:0] pat(input int s);
    case (s)
      0:       return 3'b000;
      1:       return 3'b001;
      2:       return 3'b011;
      default: return 3'b111;
    endcase
  endfunction

  task automatic model_step(input bit tk, input logic [2:0] l, input logic [2:0] r,
                            output exp_t e);
    int  pl, pr, f, s, fam, len, cls;
    bit  ok, lg;
    e.fault = 0;
    if (tk) begin
      pl = pos(l); pr = pos(r); ok = 1; f = 0; s = 0;
      if (pl < 0 || pr < 0)         ok = 0;
      else if (pl == 0 && pr == 0)  begin f = 0; s = 0; end
      else if (pr == 0)             begin f = 1; s = pl; end
      else if (pl == 0)             begin f = 2; s = pr; end
      else if (pl == 3 && pr == 3)  begin f = 3; s = 1; end
      else                          ok = 0;
      lg = 0; cls = 0;
      if (ok) begin
        if (m_pf == 0 && f == 0) begin lg = 1; cls = 0; end
        else begin
          fam = (m_pf != 0) ? m_pf : f;
          len = (fam == 3) ? 2 : 4;
          if ((f == 0 || f == fam) && s == (m_ps + 1) % len) begin lg = 1; cls = fam; end
        end
      end
      if (lg) begin
        if (cls == m_cand) m_run = (m_run < 7) ? m_run + 1 : 7;
        else begin m_cand = cls; m_run = 1; end
        m_locked = (m_run >= LOCK_N);
        if (m_locked) m_mode = m_cand;
        m_pf = f; m_ps = s;
      end else begin
        e.fault = 1;
        m_err = (m_err < 255) ? m_err + 1 : 255;
        m_run = 0; m_locked = 0;
        if (ok) begin m_pf = f; m_ps = s; end
        else begin m_pf = 0; m_ps = 0; end
      end
    end
    e.mode = m_mode; e.locked = m_locked; e.err = m_err;
  endtask

  task automatic drive(input bit tk, input logic [2:0] l, input logic [2:0] r);
    exp_t e;
    tick = tk; left_lamp = l; right_lamp = r;
    @(posedge clk);
    model_step(tk, l, r, e);
    sbq.push_back(e);
    #1;
  endtask

  task automatic gen(output logic [2:0] l, output logic [2:0] r);
    int k, f, s, len;
    k = $urandom_range(0, 9);
    if (k < 7) begin
      if (m_pf == 0) begin
        f = $urandom_range(0, 3);
        s = (f == 0) ? 0 : 1;
      end else begin
        f = m_pf;
        len = (f == 3) ? 2 : 4;
        s = (m_ps + 1) % len;
        if (s == 0) f = 0;
      end
      case (f)
        0:       begin l = 3'b000; r = 3'b000; end
        1:       begin l = pat(s); r = 3'b000; end
        2:       begin l = 3'b000; r = pat(s); end
        default: begin l = 3'b111; r = 3'b111; end
      endcase
    end else begin
      l = 3'($urandom);
      r = 3'($urandom);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_mode", mode, 0);
    chk("rst_locked", locked, 0);
    chk("rst_fault", fault, 0);
    chk("rst_err", err_cnt, 0);
    model_reset();
    tick = 1'b1; left_lamp = 3'b111; right_lamp = 3'b001;
    @(posedge clk);
    #1;
    chk("rst_hold_err", err_cnt, 0);
    chk("rst_hold_fault", fault, 0);
    #2 rst_n = 1'b1;
    tick = 1'b0;
  endtask

  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      exp_t e;
      e = sbq.pop_front();
      chk("sb_mode", mode, e.mode);
      chk("sb_locked", locked, e.locked);
      chk("sb_fault", fault, e.fault);
      chk("sb_err", err_cnt, e.err);
    end
  end

  initial begin
    logic [2:0] l, r;
    model_reset();
    do_reset();

    drive(1, 3'b001, 3'b000); drive(1, 3'b011, 3'b000);
    drive(1, 3'b111, 3'b000); drive(1, 3'b000, 3'b000);
    chk("left_lock_mode", mode, 1);
    chk("left_lock_locked", locked, 1);
    chk("left_lock_err", err_cnt, 0);

    drive(1, 3'b111, 3'b111); drive(1, 3'b000, 3'b000);
    drive(1, 3'b111, 3'b111); drive(1, 3'b000, 3'b000);
    chk("haz_lock_mode", mode, 3);
    chk("haz_lock_locked", locked, 1);
    drive(1, 3'b000, 3'b000); drive(1, 3'b000, 3'b001);
    chk("haz_unlock_locked", locked, 0);
    chk("haz_unlock_mode", mode, 3);

    drive(1, 3'b000, 3'b011); drive(1, 3'b000, 3'b111); drive(1, 3'b000, 3'b000);
    drive(1, 3'b001, 3'b000); drive(1, 3'b011, 3'b000);
    drive(1, 3'b111, 3'b000); drive(1, 3'b000, 3'b000);
    drive(1, 3'b001, 3'b000);
    drive(1, 3'b111, 3'b000);
    chk("skip_fault", fault, 1);
    chk("skip_err", err_cnt, 1);
    chk("skip_locked", locked, 0);
    chk("skip_mode", mode, 1);
    drive(0, 3'b000, 3'b000);
    chk("skip_fault_pulse", fault, 0);
    drive(1, 3'b000, 3'b000); drive(1, 3'b001, 3'b000);
    drive(1, 3'b011, 3'b000); drive(1, 3'b111, 3'b000);
    chk("relock_locked", locked, 1);
    chk("relock_mode", mode, 1);

    drive(1, 3'b011, 3'b011);
    chk("inv_fault", fault, 1);
    chk("inv_err", err_cnt, 2);
    drive(1, 3'b001, 3'b000);
    chk("inv_next_fault", fault, 0);

    repeat (300) drive(1, 3'b101, 3'b010);
    chk("sat_err", err_cnt, 255);
    repeat (10) drive(0, 3'b011, 3'b011);
    chk("idle_err", err_cnt, 255);

    do_reset();
    repeat (3) drive(1, 3'b010, 3'b000);
    drive(1, 3'b000, 3'b001); drive(1, 3'b000, 3'b011);
    drive(1, 3'b000, 3'b111); drive(1, 3'b000, 3'b000);
    chk("right_lock_mode", mode, 2);
    chk("right_lock_err", err_cnt, 3);
    do_reset();
    repeat (4) drive(1, 3'b000, 3'b000);
    chk("post_rst_mode", mode, 0);
    chk("post_rst_locked", locked, 1);

    for (int i = 0; i < 2000; i++) begin
      if (i == 1000) do_reset();
      gen(l, r);
      drive(($urandom_range(0, 99) < 90), l, r);
    end

    repeat (3) @(negedge clk);
    chk("sb_drained", sbq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
